// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle RISC-V sequencing FSM with handshaked memories
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   opcode               instruction[6:0] from the instruction register
//   branch_cond          branch comparator result (1 = taken)
//   imem_req/imem_ready  instruction fetch handshake
//   dmem_req/dmem_we/dmem_ready  data access handshake (we: 1 store, 0 load)
//   ir_we, pc_we, pc_src datapath enables/selects for IR and PC
//   reg_we, wb_sel       register-file write enable and writeback source
//   alu_src, alu_op      ALU operand-B source and operation class
//   imm_sel              immediate format (00 I, 01 S, 10 B)
//   illegal              sticky trap flag (held until reset)
//   instret              retired-instruction count, wraps modulo 2^XLEN

module multicycle_controller #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [6:0]      opcode,
  input  logic            branch_cond,
  output logic            imem_req,
  input  logic            imem_ready,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ready,
  output logic            ir_we,
  output logic            pc_we,
  output logic            pc_src,
  output logic            reg_we,
  output logic            wb_sel,
  output logic            alu_src,
  output logic [1:0]      alu_op,
  output logic [1:0]      imm_sel,
  output logic            illegal,
  output logic [XLEN-1:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  typedef enum logic [2:0] {
    C_NONE, C_R, C_I, C_L, C_S, C_B
  } cls_t;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_L = 7'b0000011;
  localparam logic [6:0] OP_S = 7'b0100011;
  localparam logic [6:0] OP_B = 7'b1100011;

  state_t state;
  cls_t   cls;
  cls_t   dec_cls;

  always_comb begin
    case (opcode)
      OP_R:    dec_cls = C_R;
      OP_I:    dec_cls = C_I;
      OP_L:    dec_cls = C_L;
      OP_S:    dec_cls = C_S;
      OP_B:    dec_cls = C_B;
      default: dec_cls = C_NONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_FETCH;
      cls     <= C_NONE;
      instret <= '0;
    end else begin
      case (state)
        S_FETCH:  if (imem_ready) state <= S_DECODE;
        S_DECODE: begin
          cls   <= dec_cls;
          state <= (dec_cls == C_NONE) ? S_TRAP : S_EXEC;
        end
        S_EXEC: begin
          case (cls)
            C_R, C_I: state <= S_WB;
            C_L, C_S: state <= S_MEM;
            C_B:      state <= S_FETCH;
            default:  state <= S_TRAP;
          endcase
        end
        S_MEM:    if (dmem_ready) state <= (cls == C_L) ? S_WB : S_FETCH;
        S_WB:     state <= S_FETCH;
        S_TRAP:   state <= S_TRAP;
        default:  state <= S_FETCH;
      endcase
      // The final pc_we of every instruction is its retirement point.
      if (pc_we) instret <= instret + XLEN'(1);
    end
  end

  // Outputs decode from state/cls plus the same-cycle ready qualifiers;
  // everything is forced low while rst is high so an abort writes nothing.
  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    pc_src   = 1'b0;
    reg_we   = 1'b0;
    wb_sel   = 1'b0;
    alu_src  = 1'b0;
    alu_op   = 2'b00;
    imm_sel  = 2'b00;
    illegal  = 1'b0;
    if (!rst) begin
      if (state == S_EXEC || state == S_MEM || state == S_WB) begin
        case (cls)
          C_R: begin alu_src = 1'b0; alu_op = 2'b10; end
          C_I: begin alu_src = 1'b1; imm_sel = 2'b00; alu_op = 2'b10; end
          C_L: begin alu_src = 1'b1; imm_sel = 2'b00; alu_op = 2'b00; end
          C_S: begin alu_src = 1'b1; imm_sel = 2'b01; alu_op = 2'b00; end
          C_B: begin alu_src = 1'b0; imm_sel = 2'b10; alu_op = 2'b01; end
          default: ;
        endcase
      end
      case (state)
        S_FETCH: begin
          imem_req = 1'b1;
          ir_we    = imem_ready;
        end
        S_EXEC: begin
          if (cls == C_B) begin
            pc_we  = 1'b1;
            pc_src = branch_cond;
          end
        end
        S_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = (cls == C_S);
          if (cls == C_S && dmem_ready) pc_we = 1'b1;
        end
        S_WB: begin
          reg_we = 1'b1;
          wb_sel = (cls == C_L);
          pc_we  = 1'b1;
        end
        S_TRAP:  illegal = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Sequencing FSM that turns the RISC-V core into a multi-cycle machine with handshaked instruction and data memories. It decodes the opcode of the latched instruction and steps the datapath (PC, instruction register, immediate generator, ALU, register file, data memory) through FETCH/DECODE/EXEC/MEM/WB. It also counts retired instructions and traps on unsupported opcodes.

## Interface
- `XLEN`, 32: width of `instret` counter.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `opcode`  in  7  `instruction[6:0]` from the instruction register.
- `branch_cond`  in  1  comparator result for current branch (1 = taken).
- `imem_req`  out  1  instruction fetch request.
- `imem_ready`  in  1  fetch data valid; instruction captured this cycle.
- `dmem_req`  out  1  data access request.
- `dmem_we`  out  1  1 = store, 0 = load; valid while `dmem_req`=1.
- `dmem_ready`  in  1  data access complete.
- `ir_we`  out  1  load instruction register.
- `pc_we`  out  1  update PC.
- `pc_src`  out  1  0 = PC+4, 1 = PC+immediate.
- `reg_we`  out  1  register-file write enable.
- `wb_sel`  out  1  0 = ALU result, 1 = load data.
- `alu_src`  out  1  0 = rs2, 1 = immediate.
- `alu_op`  out  2  00 add, 01 subtract/compare, 10 funct-decoded.
- `imm_sel`  out  2  00 I, 01 S, 10 B.
- `illegal`  out  1  sticky trap flag.
- `instret`  out  XLEN  retired-instruction count.

## Operation
- Opcode classes: R 0110011, I 0010011, L 0000011, S 0100011, B 1100011. Any other opcode is illegal.
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP. The class register `cls` is captured in DECODE.
- FETCH: `imem_req`=1. On `imem_ready`: `ir_we`=1 and go to DECODE. Otherwise stay.
- DECODE: classify `opcode` and latch `cls`. Legal opcodes go to EXEC. Illegal opcodes go to TRAP.
- Decode outputs, driven from `cls` in EXEC/MEM/WB:
  - R: `alu_src`=0, `alu_op`=10.
  - I: `alu_src`=1, `imm_sel`=00, `alu_op`=10.
  - L: `alu_src`=1, `imm_sel`=00, `alu_op`=00.
  - S: `alu_src`=1, `imm_sel`=01, `alu_op`=00.
  - B: `alu_src`=0, `imm_sel`=10, `alu_op`=01.
  - All other states drive 0.
- EXEC:
  - R/I go to WB.
  - L/S go to MEM.
  - B: `pc_we`=1, `pc_src`=`branch_cond`, `instret`+1, go to FETCH.
- MEM: `dmem_req`=1 and `dmem_we`=(cls==S). On `dmem_ready`:
  - L goes to WB.
  - S: `pc_we`=1, `pc_src`=0, `instret`+1, go to FETCH.
- WB: `reg_we`=1, `wb_sel`=(cls==L), `pc_we`=1, `pc_src`=0, `instret`+1, go to FETCH.
- TRAP: `illegal`=1. All other strobes are 0. `instret` is frozen. Only `rst` exits TRAP.
- `instret` wraps modulo 2^XLEN.

## Timing
- Outputs are combinational from state, `cls` and handshake inputs (Moore, plus same-cycle `ir_we`/`pc_we` qualifiers).
- While `rst`=1, every output is 0: `imem_req`, `dmem_req`, all enables and selects, and `illegal`. On the next clock edge, state is FETCH, `cls` is cleared and `instret` is 0.
- The first cycle after `rst` falls has `imem_req`=1.
- Reset mid-operation (any state, including MEM with `dmem_req` high) aborts immediately. No PC or register write occurs in that cycle.
- Handshake rules:
  - `imem_req`/`dmem_req` stay high until the matching ready is sampled high on a rising edge.
  - The request drops in the following cycle.
  - A ready input is ignored while its request is low.
  - Ready may already be high when the request rises; that counts as zero wait.
- Cycles per instruction with zero-wait memories: R/I 4, L 5, S 4, B 3. Each memory wait cycle adds 1.
- `pc_we` and `reg_we` pulse for exactly one cycle per instruction.
- `instret` increments on the same edge as the final `pc_we`.
- `imem_req` and `dmem_req` are never high in the same cycle.

## Test plan
- Reset, then zero-wait memories, then R-type 0110011 → `imem_req` high on cycle 1, `reg_we`=1 on cycle 4 with `wb_sel`=0, `instret`=1 after cycle 4.
- Load 0000011 with `dmem_ready` delayed 3 cycles → `dmem_req` high for 4 cycles with `dmem_we`=0, then WB with `wb_sel`=1, `imm_sel`=00, total 8 cycles.
- Store 0100011, then branch 1100011 with `branch_cond`=1, then branch with `branch_cond`=0:
  - Store: `dmem_we`=1, `imm_sel`=01, no `reg_we`.
  - Branches: `pc_src`=1 and then 0 in EXEC, `imm_sel`=10, 3 cycles each.
  - `instret`=3 at the end.
- Illegal opcode 1111111 → TRAP after DECODE, `illegal` stays 1 for 20 cycles with no strobes and `instret` unchanged; `rst` clears `illegal` and restarts FETCH.
- Assert `rst` during MEM of a store with `dmem_req` high → all outputs 0 that cycle, no `pc_we`, `instret`=0, FETCH on release.
- Preload `instret`=2^XLEN−1 via a forced counter value, retire one R-type → `instret` wraps to 0.
